// File: rtl/traffic_countdown_display.sv
// rtl/traffic_countdown_display.sv - two-digit BCD phase countdown on a muxed common-anode 7-segment display.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the display during the last three seconds.
module traffic_countdown_display #(
  parameter int PHASE_SEC = 20,
  parameter int MUX_DIV   = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       phase_err
);

  localparam int RW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(MUX_DIV - 1);
  localparam logic [3:0] LOAD_TENS = 4'(PHASE_SEC / 10);
  localparam logic [3:0] LOAD_ONES = 4'(PHASE_SEC % 10);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } sel_e;

  logic [2:0]    lights;
  logic [2:0]    prev_lights_q;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [RW-1:0] ref_cnt_q;
  sel_e          sel_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          phase_err_q;
  logic          legal;
  logic          load;
  logic          ref_wrap;
`ifdef COUNTDOWN_BLINK_EN
  logic          blink_q, blink_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign lights   = {red, yellow, green};
  assign legal    = (lights == 3'b100) || (lights == 3'b010) || (lights == 3'b001);
  // prev_lights also tracks illegal codes, so the first legal cycle afterwards always reloads
  assign load     = legal && (lights != prev_lights_q);
  assign ref_wrap = (ref_cnt_q == REF_LAST);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
`ifdef COUNTDOWN_BLINK_EN
    blink_d = blink_q;
`endif
    if (load) begin
      tens_d = LOAD_TENS;
      ones_d = LOAD_ONES;
`ifdef COUNTDOWN_BLINK_EN
      blink_d = 1'b0;
`endif
    end else if (legal && sec_tick) begin
`ifdef COUNTDOWN_BLINK_EN
      blink_d = ~blink_q;
`endif
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    if (!legal) begin
      seg_d = SEG_DASH;
    end else if (sel_q == SEL_ONES) begin
      seg_d = seg7(ones_q);
    end else if (tens_q != 4'd0) begin
      seg_d = seg7(tens_q);
    end
    an_d = (sel_q == SEL_ONES) ? 2'b10 : 2'b01;
`ifdef COUNTDOWN_BLINK_EN
    if (legal && blink_q && (tens_q == 4'd0) && (ones_q <= 4'd3)) begin
      an_d = 2'b11;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_lights_q <= 3'b000;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      ref_cnt_q     <= '0;
      sel_q         <= SEL_ONES;
      seg_q         <= SEG_BLANK;
      an_q          <= 2'b11;
      phase_err_q   <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
      blink_q       <= 1'b0;
`endif
    end else begin
      prev_lights_q <= lights;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      phase_err_q   <= ~legal;
`ifdef COUNTDOWN_BLINK_EN
      blink_q       <= blink_d;
`endif
      if (ref_wrap) begin
        ref_cnt_q <= '0;
        sel_q     <= (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
      end
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb/tb_traffic_countdown_display.sv - vector table, random stimulus and reset checks for traffic_countdown_display.
module tb_traffic_countdown_display;

  localparam int PHASE_SEC = 20;
  localparam int MUX_DIV   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic       red, yellow, green;
  logic [6:0] seg;
  logic [1:0] an;
  logic       phase_err;

  traffic_countdown_display #(.PHASE_SEC(PHASE_SEC), .MUX_DIV(MUX_DIV)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .red(red), .yellow(yellow), .green(green),
    .seg(seg), .an(an), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] digits [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: integer seconds left, last lights, edges since reset
  int         m_count;
  int         m_n;
  logic [2:0] m_prev;
  int         last_sel;
`ifdef COUNTDOWN_BLINK_EN
  bit         m_blink;
`endif

  typedef struct {
    logic [2:0] lights;
    bit         tick;
    int         rep;
    bit         exp_err;
    int         exp_count;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [6:0] disp(int count, int sel, bit illegal);
    if (illegal) return 7'b0111111;
    if (sel == 0) return digits[count % 10];
    if (count / 10 == 0) return 7'b1111111;
    return digits[count / 10];
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_n     = 0;
    m_prev  = 3'b000;
`ifdef COUNTDOWN_BLINK_EN
    m_blink = 0;
`endif
  endtask

  task automatic step(input logic [2:0] lights, input bit tick);
    bit         illegal;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    {red, yellow, green} = lights;
    sec_tick = tick;
    @(posedge clk);
    illegal  = ($countones(lights) != 1);
    last_sel = (m_n / MUX_DIV) % 2;
    e_seg    = disp(m_count, last_sel, illegal);
    e_an     = (last_sel == 0) ? 2'b10 : 2'b01;
`ifdef COUNTDOWN_BLINK_EN
    if (!illegal && m_blink && m_count <= 3) e_an = 2'b11;
`endif
    if (!illegal) begin
      if (lights != m_prev) begin
        m_count = PHASE_SEC;
`ifdef COUNTDOWN_BLINK_EN
        m_blink = 0;
`endif
      end else if (tick) begin
        if (m_count > 0) m_count--;
`ifdef COUNTDOWN_BLINK_EN
        m_blink = !m_blink;
`endif
      end
    end
    m_prev = lights;
    m_n++;
    @(negedge clk);
    check("model_seg", seg, e_seg);
    check("model_an", {5'b0, an}, {5'b0, e_an});
    check("model_err", {6'b0, phase_err}, {6'b0, illegal});
  endtask

  initial begin
    logic [2:0] cur;
    reset = 1'b1;
    sec_tick = 1'b0;
    {red, yellow, green} = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 7'b1111111);
    check("reset_an", {5'b0, an}, 7'b0000011);
    check("reset_err", {6'b0, phase_err}, 7'b0);
    reset = 1'b0;

    tbl.push_back('{lights: 3'b100, tick: 0, rep: 1,  exp_err: 0, exp_count: 20});
    tbl.push_back('{lights: 3'b100, tick: 1, rep: 11, exp_err: 0, exp_count: 9});
    tbl.push_back('{lights: 3'b001, tick: 1, rep: 1,  exp_err: 0, exp_count: 20});
    tbl.push_back('{lights: 3'b001, tick: 1, rep: 5,  exp_err: 0, exp_count: 15});
    tbl.push_back('{lights: 3'b110, tick: 1, rep: 3,  exp_err: 1, exp_count: 15});
    tbl.push_back('{lights: 3'b010, tick: 0, rep: 1,  exp_err: 0, exp_count: 20});
    tbl.push_back('{lights: 3'b010, tick: 1, rep: 25, exp_err: 0, exp_count: 0});
    tbl.push_back('{lights: 3'b000, tick: 1, rep: 2,  exp_err: 1, exp_count: 0});
    tbl.push_back('{lights: 3'b100, tick: 0, rep: 1,  exp_err: 0, exp_count: 20});

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].rep) step(tbl[i].lights, tbl[i].tick);
      // hold two full refresh periods so both digit slots are observed
      for (int k = 0; k < 2 * MUX_DIV; k++) begin
        step(tbl[i].lights, 1'b0);
        check($sformatf("tbl%0d_seg", i), seg, disp(tbl[i].exp_count, last_sel, tbl[i].exp_err));
        check($sformatf("tbl%0d_err", i), {6'b0, phase_err}, {6'b0, tbl[i].exp_err});
      end
    end

    cur = 3'b100;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) cur = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 29) == 0) step(3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      else step(cur, $urandom_range(0, 2) == 0);
    end

    step(3'b000, 1'b0);
    step(3'b100, 1'b0);
    repeat (7) step(3'b100, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midreset_seg", seg, 7'b1111111);
    check("midreset_an", {5'b0, an}, 7'b0000011);
    check("midreset_err", {6'b0, phase_err}, 7'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(3'b100, 1'b0);
    check("post_reset_seg", seg, 7'b1000000);
    check("post_reset_an", {5'b0, an}, 7'b0000010);
    repeat (2 * MUX_DIV + 20) step(3'b100, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_countdown_display.md
# traffic_countdown_display

Downstream consumer of the traffic-light controller's one-hot `red`/`yellow`/`green` outputs and its 1 Hz pulse. Tracks the seconds remaining in the current light phase as a two-digit BCD countdown. Drives a time-multiplexed, common-anode, two-digit 7-segment display. Flags illegal light encodings.

## Interface
- `PHASE_SEC`, 20: phase length in seconds, legal range 1..99.
- `MUX_DIV`, 50_000: clk cycles per digit-refresh slot (1 kHz at 50 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `sec_tick`  in  1  one-cycle 1 Hz pulse, synchronous to `clk`.
- `red`  in  1  controller red output.
- `yellow`  in  1  controller yellow output.
- `green`  in  1  controller green output.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  2  digit enables, active-low; bit 0 = ones digit, bit 1 = tens digit.
- `phase_err`  out  1  high while the light inputs are not exactly one-hot.

## Operation
- Registers:
  - `prev_lights[2:0]`: last sampled {red,yellow,green}.
  - `tens[3:0]`, `ones[3:0]`: BCD count.
  - `ref_cnt`: counts 0..MUX_DIV-1.
  - `sel`: digit select.
- Phase change: `{red,yellow,green}` is one-hot and differs from `prev_lights`.
  - On a phase change, load tens/ones from PHASE_SEC (e.g. 20 -> 2,0).
  - `prev_lights` updates every cycle.
- Decrement: on `sec_tick` with no phase change, decrement in BCD.
  - ones>0: ones-1.
  - ones==0 and tens>0: ones=9, tens-1.
  - 00: hold at 00, no wrap.
- Simultaneous phase change and `sec_tick`: load wins, no decrement. The controller changes phase on the tick edge, so this is the normal case.
- Illegal encoding (000, or more than one bit set):
  - `phase_err`=1; count frozen; both digits show dash (0111111).
  - On the return to one-hot, the first legal cycle counts as a phase change and reloads.
- Refresh:
  - `ref_cnt` wraps at MUX_DIV-1; `sel` toggles on the wrap.
  - sel=0: an=10, ones digit shown. sel=1: an=01, tens digit shown.
- Leading-zero blanking: tens==0 -> tens slot shows blank (1111111) while an=01 still asserts.
- Encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset values:
  - Outputs: seg=1111111, an=11, phase_err=0.
  - Internal: tens=ones=0, prev_lights=000, ref_cnt=0, sel=0.
- Reset mid-operation blanks the display immediately (asynchronous).

## Timing
- `seg`, `an`, `phase_err` are registered. Each reflects state from the previous clock edge.
- Count load/decrement occurs at the edge where the phase change or `sec_tick` is sampled. `seg` shows the new value one clock later, if that digit is selected.
- `phase_err` asserts/deasserts 1 clock after the illegal/legal input is sampled.
- Digit switch: `an` changes 1 clock after the `ref_cnt` wrap. Each digit is lit for exactly MUX_DIV cycles.
- First clock after reset release: an=10 with ones digit 0. Count shows 0 until the first phase change.
- Held inputs do not re-trigger a load; only a change relative to `prev_lights` does.

## Configuration
- `COUNTDOWN_BLINK_EN` defined:
  - Add register `blink`, cleared on load and toggled on each accepted `sec_tick`.
  - While count ≤ 03, `phase_err`=0 and `blink`=1, force an=11 (display dark). The digit alternates lit/dark each second.
  - At 00, blinking continues until the next load.
- Not defined: no `blink` register; digits are always lit per normal refresh.

## Test plan
All scenarios use MUX_DIV=4 and PHASE_SEC=20.
- Reset, then red=1: the cycle after the load, count=20. Slot sel=1 gives an=01, seg=0100100; slot sel=0 gives an=10, seg=1000000.
- 11 ticks in red -> count 09. Tens slot blank (1111111); ones slot seg=0010000. Ticks at 10 -> 09 must show the BCD borrow.
- Tick pulsed in the same cycle red->green -> count exactly 20, no 19.
- 25 ticks without a phase change -> count holds 00, no wrap to 99.
- Inputs 110 for 3 cycles, then 010:
  - During 110: phase_err=1 and both slots 0111111.
  - After 010: phase_err=0 and count 20.
- Assert reset mid-countdown at count 13 -> same cycle seg=1111111, an=11. After release, count=0 until the next phase change.
- With `COUNTDOWN_BLINK_EN`: ticks 17..20 show an=11 during alternate seconds at counts 03..00.
